// File: rtl/fpga_system_pio_pkg.sv
// rtl/fpga_system_pio_pkg.sv - shared register map and edge-type encodings for the PIO blocks
package fpga_system_pio_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_debounce.sv
// rtl/pio_debounce.sv - one-bit debounce filter; output follows input after DEBOUNCE_CYCLES stable cycles
module pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Counter only runs while the input disagrees with the output; any bounce back restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      dout <= din;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fpga_system_input_pio.sv
// rtl/fpga_system_input_pio.sv - Avalon-MM input PIO with edge capture and masked level irq
// Optional per-bit debounce filter: FPGA_SYSTEM_INPUT_PIO_DEBOUNCE_EN
module fpga_system_input_pio
  import fpga_system_pio_pkg::*;
#(
  parameter int WIDTH           = 18,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  logic [WIDTH-1:0]  sync1, sync2, filt, filt_d;
  logic [WIDTH-1:0]  irqmask, edgecap;
  logic [WIDTH-1:0]  rise, fall, edge_sel, edges, w1c;
  logic [1:0]        prime;
  logic              wr, rd;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_wdata;

  assign wr = chipselect && !write_n;
  assign rd = chipselect && write_n;
  assign unused_wdata = &{1'b0, writedata};

`ifdef FPGA_SYSTEM_INPUT_PIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    pio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (sync2[i]),
      .dout    (filt[i])
    );
  end
`else
  assign filt = sync2;
`endif

  assign rise = filt & ~filt_d;
  assign fall = ~filt & filt_d;

  always_comb begin
    edge_sel = rise;
    if (EDGE_TYPE == EDGE_FALLING)  edge_sel = fall;
    else if (EDGE_TYPE == EDGE_ANY) edge_sel = rise | fall;
  end

  // Hold off detection until filt_d has seen real input, so inputs high at release are not edges.
  assign edges = (prime == 2'd3) ? edge_sel : '0;
  assign w1c   = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = filt;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecap;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      filt_d   <= '0;
      prime    <= '0;
      irqmask  <= '0;
      edgecap  <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      sync1  <= in_port;
      sync2  <= sync1;
      filt_d <= filt;
      if (prime != 2'd3) prime <= prime + 2'd1;
      if (wr && address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
      // A new edge in the same cycle as its clear keeps the bit set.
      edgecap <= (edgecap & ~w1c) | edges;
      irq     <= |(edgecap & irqmask);
      if (rd) readdata <= rd_mux;
    end
  end

endmodule
